// File: rtl/dsi_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsi_cfg_pkg: address map, status bit positions, AXI response codes    |
// | and FSM state types shared by the DSI config AXI-Lite slave.          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package dsi_cfg_pkg;

   localparam logic [6:0] CFG_BASE    = 7'h00;
   localparam logic [6:0] CMD_ADDR    = 7'h20;
   localparam logic [6:0] STATUS_ADDR = 7'h24;

   localparam int STAT_CMD_VALID_BIT = 10;
   localparam int STAT_TX_BUSY_BIT   = 11;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [0:0] {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wr_state_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/dsi_cfg_axil_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsi_cfg_axil_slave: AXI-Lite config/command register block for DSI.   |
// | Optional DSI_CFG_SLVERR_EN: SLVERR on unmapped / read-only accesses.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dsi_cfg_axil_slave
   import dsi_cfg_pkg::*;
#(
   parameter logic [31:0] CTRL_RST = 32'h0000_0000,
   parameter int          NUM_CFG  = 8
) (
   input  logic                  i_axi_clk,
   input  logic                  i_rst,
   input  logic [6:0]            i_axi_awaddr,
   input  logic                  i_axi_awvalid,
   output logic                  o_axi_awready,
   input  logic [31:0]           i_axi_wdata,
   input  logic                  i_axi_wvalid,
   output logic                  o_axi_wready,
   output logic [1:0]            o_axi_bresp,
   output logic                  o_axi_bvalid,
   input  logic                  i_axi_bready,
   input  logic [6:0]            i_axi_araddr,
   input  logic                  i_axi_arvalid,
   output logic                  o_axi_arready,
   output logic [31:0]           o_axi_rdata,
   output logic [1:0]            o_axi_rresp,
   output logic                  o_axi_rvalid,
   input  logic                  i_axi_rready,
   output logic [NUM_CFG*32-1:0] o_cfg,
   output logic                  o_cmd_valid,
   output logic [31:0]           o_cmd_data,
   input  logic                  i_cmd_ready,
   input  logic                  i_tx_busy
);

   wr_state_t r_wr_state, w_wr_next;
   rd_state_t r_rd_state, w_rd_next;

   logic                       r_rdy_en;
   logic                       r_aw_lat, r_w_lat;
   logic [4:0]                 r_awword;
   logic [31:0]                r_wdata;
   logic [NUM_CFG-1:0][31:0]   r_cfg;
   logic [1:0]                 r_bresp;
   logic [31:0]                r_rdata;
   logic [1:0]                 r_rresp;
   logic                       r_cmd_valid;
   logic [31:0]                r_cmd_data;

   logic        w_aw_hs, w_w_hs, w_ar_hs;
   logic        w_commit, w_b_hs;
   logic        w_wr_cfg, w_wr_cmd, w_wr_ok;
   logic [1:0]  w_wr_resp;
   logic [4:0]  w_rword;
   logic [31:0] w_rd_val;
   logic        w_rd_ok;
   logic [1:0]  w_rd_resp;
   logic        w_unused;

   // r_rdy_en keeps every ready low until the first edge after reset release
   assign o_axi_awready = r_rdy_en & ~r_aw_lat & (r_wr_state == W_IDLE);
   assign o_axi_wready  = r_rdy_en & ~r_w_lat  & (r_wr_state == W_IDLE);
   assign o_axi_arready = r_rdy_en & (r_rd_state == R_IDLE);
   assign o_axi_bvalid  = (r_wr_state == W_RESP);
   assign o_axi_bresp   = r_bresp;
   assign o_axi_rvalid  = (r_rd_state == R_DATA);
   assign o_axi_rdata   = r_rdata;
   assign o_axi_rresp   = r_rresp;
   assign o_cfg         = r_cfg;
   assign o_cmd_valid   = r_cmd_valid;
   assign o_cmd_data    = r_cmd_data;

   assign w_aw_hs = i_axi_awvalid & o_axi_awready;
   assign w_w_hs  = i_axi_wvalid  & o_axi_wready;
   assign w_ar_hs = i_axi_arvalid & o_axi_arready;

   always_comb begin
      w_wr_cfg = 1'b0;
      for (int i = 0; i < NUM_CFG; i++) begin
         if (r_awword == CFG_BASE[6:2] + 5'(i)) w_wr_cfg = 1'b1;
      end
   end

   assign w_wr_cmd = (r_awword == CMD_ADDR[6:2]);
   assign w_wr_ok  = w_wr_cfg | w_wr_cmd;

   always_comb begin
      w_rword  = i_axi_araddr[6:2];
      w_rd_val = '0;
      w_rd_ok  = 1'b0;
      for (int i = 0; i < NUM_CFG; i++) begin
         if (w_rword == CFG_BASE[6:2] + 5'(i)) begin
            w_rd_val = r_cfg[i];
            w_rd_ok  = 1'b1;
         end
      end
      if (w_rword == CMD_ADDR[6:2]) begin
         w_rd_val = r_cmd_data;
         w_rd_ok  = 1'b1;
      end
      if (w_rword == STATUS_ADDR[6:2]) begin
         w_rd_val[STAT_CMD_VALID_BIT] = r_cmd_valid;
         w_rd_val[STAT_TX_BUSY_BIT]   = i_tx_busy;
         w_rd_ok                      = 1'b1;
      end
   end

`ifdef DSI_CFG_SLVERR_EN
   assign w_wr_resp = w_wr_ok ? OKAY : SLVERR;
   assign w_rd_resp = w_rd_ok ? OKAY : SLVERR;
`else
   assign w_wr_resp = OKAY;
   assign w_rd_resp = OKAY;
`endif

   assign w_unused = ^{i_axi_awaddr[1:0], i_axi_araddr[1:0], w_wr_ok, w_rd_ok};

   // A command write waits while the previous command is still unconsumed
   always_comb begin
      w_wr_next = r_wr_state;
      w_commit  = 1'b0;
      w_b_hs    = 1'b0;
      case (r_wr_state)
         W_IDLE: begin
            if (r_aw_lat && r_w_lat && !(w_wr_cmd && r_cmd_valid)) begin
               w_commit  = 1'b1;
               w_wr_next = W_RESP;
            end
         end
         W_RESP: begin
            if (i_axi_bready) begin
               w_b_hs    = 1'b1;
               w_wr_next = W_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      w_rd_next = r_rd_state;
      case (r_rd_state)
         R_IDLE: if (w_ar_hs)      w_rd_next = R_DATA;
         R_DATA: if (i_axi_rready) w_rd_next = R_IDLE;
      endcase
   end

   always_ff @(posedge i_axi_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_state <= W_IDLE;
         r_rd_state <= R_IDLE;
      end else begin
         r_wr_state <= w_wr_next;
         r_rd_state <= w_rd_next;
      end
   end

   always_ff @(posedge i_axi_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rdy_en    <= 1'b0;
         r_aw_lat    <= 1'b0;
         r_w_lat     <= 1'b0;
         r_awword    <= '0;
         r_wdata     <= '0;
         r_cfg       <= '0;
         r_cfg[0]    <= CTRL_RST;
         r_bresp     <= OKAY;
         r_rdata     <= '0;
         r_rresp     <= OKAY;
         r_cmd_valid <= 1'b0;
         r_cmd_data  <= '0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_aw_hs) begin
            r_aw_lat <= 1'b1;
            r_awword <= i_axi_awaddr[6:2];
         end
         if (w_w_hs) begin
            r_w_lat <= 1'b1;
            r_wdata <= i_axi_wdata;
         end
         if (w_b_hs) begin
            r_aw_lat <= 1'b0;
            r_w_lat  <= 1'b0;
         end
         if (r_cmd_valid && i_cmd_ready) r_cmd_valid <= 1'b0;
         if (w_commit) begin
            r_bresp <= w_wr_resp;
            for (int i = 0; i < NUM_CFG; i++) begin
               if (r_awword == CFG_BASE[6:2] + 5'(i)) r_cfg[i] <= r_wdata;
            end
            if (w_wr_cmd) begin
               r_cmd_valid <= 1'b1;
               r_cmd_data  <= r_wdata;
            end
         end
         if (w_ar_hs) begin
            r_rdata <= w_rd_val;
            r_rresp <= w_rd_resp;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dsi_cfg_axil_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dsi_cfg_axil_slave: directed and random bench for the DSI config   |
// | AXI-Lite slave against a register-map reference model.               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_dsi_cfg_axil_slave;

   localparam logic [31:0] TB_CTRL_RST = 32'h1234_5678;
   localparam int          TB_NUM_CFG  = 8;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [6:0]               awaddr;
   logic                     awvalid;
   logic                     awready;
   logic [31:0]              wdata;
   logic                     wvalid;
   logic                     wready;
   logic [1:0]               bresp;
   logic                     bvalid;
   logic                     bready;
   logic [6:0]               araddr;
   logic                     arvalid;
   logic                     arready;
   logic [31:0]              rdata;
   logic [1:0]               rresp;
   logic                     rvalid;
   logic                     rready;
   logic [TB_NUM_CFG*32-1:0] cfg;
   logic                     cmd_valid;
   logic [31:0]              cmd_data;
   logic                     cmd_ready;
   logic                     tx_busy;

   int n_total = 0;
   int n_bad   = 0;

   logic [31:0] m_cfg [TB_NUM_CFG];
   logic [31:0] m_cmd;
   logic        m_cmd_valid;

   dsi_cfg_axil_slave #(
      .CTRL_RST (TB_CTRL_RST),
      .NUM_CFG  (TB_NUM_CFG)
   ) dut (
      .i_axi_clk     (clk),
      .i_rst         (rst),
      .i_axi_awaddr  (awaddr),
      .i_axi_awvalid (awvalid),
      .o_axi_awready (awready),
      .i_axi_wdata   (wdata),
      .i_axi_wvalid  (wvalid),
      .o_axi_wready  (wready),
      .o_axi_bresp   (bresp),
      .o_axi_bvalid  (bvalid),
      .i_axi_bready  (bready),
      .i_axi_araddr  (araddr),
      .i_axi_arvalid (arvalid),
      .o_axi_arready (arready),
      .o_axi_rdata   (rdata),
      .o_axi_rresp   (rresp),
      .o_axi_rvalid  (rvalid),
      .i_axi_rready  (rready),
      .o_cfg         (cfg),
      .o_cmd_valid   (cmd_valid),
      .o_cmd_data    (cmd_data),
      .i_cmd_ready   (cmd_ready),
      .i_tx_busy     (tx_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < TB_NUM_CFG; i++) m_cfg[i] = (i == 0) ? TB_CTRL_RST : 32'h0;
      m_cmd       = 32'h0;
      m_cmd_valid = 1'b0;
   endtask

   function automatic bit model_mapped_rd(input logic [6:0] a);
      int w = int'(a) / 4;
      return (w < TB_NUM_CFG) || (w == 8) || (w == 9);
   endfunction

   function automatic bit model_mapped_wr(input logic [6:0] a);
      int w = int'(a) / 4;
      return (w < TB_NUM_CFG) || (w == 8);
   endfunction

   function automatic logic [31:0] model_rd(input logic [6:0] a);
      int w = int'(a) / 4;
      if (w < TB_NUM_CFG) return m_cfg[w];
      if (w == 8) return m_cmd;
      if (w == 9) return (32'(tx_busy) * 2048) + (32'(m_cmd_valid) * 1024);
      return 32'h0;
   endfunction

   function automatic logic [1:0] model_resp(input bit mapped);
`ifdef DSI_CFG_SLVERR_EN
      return mapped ? 2'b00 : 2'b10;
`else
      return 2'b00;
`endif
   endfunction

   // lat = edges from the later of the AW/W handshakes until bvalid is seen
   task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input int da, input int dw,
                            output logic [1:0] resp, output int lat);
      bit ad = 0;
      bit wd = 0;
      bit ah, wh;
      int cyc = 0;
      awaddr = a;
      wdata  = d;
      bready = 1'b1;
      while (!(ad && wd) && cyc < 40) begin
         awvalid = !ad && (cyc >= da);
         wvalid  = !wd && (cyc >= dw);
         ah = awvalid && awready;
         wh = wvalid && wready;
         tick();
         if (ah) ad = 1;
         if (wh) wd = 1;
         cyc++;
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      if (!(ad && wd)) check_val("aw_w_timeout", 64'(cyc), 64'(0));
      lat = 0;
      while (!bvalid && lat < 80) begin
         tick();
         lat++;
      end
      if (!bvalid) begin
         check_val("b_timeout", 64'(bvalid), 64'(1));
         lat = -1;
      end
      resp = bresp;
      tick();
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [6:0] a, input int hold, output logic [31:0] d, output logic [1:0] r);
      int n = 0;
      araddr  = a;
      arvalid = 1'b1;
      rready  = 1'b0;
      while (!arready && n < 20) begin
         tick();
         n++;
      end
      if (!arready) check_val("ar_timeout", 64'(arready), 64'(1));
      tick();
      arvalid = 1'b0;
      check_val("rvalid_after_ar", 64'(rvalid), 64'(1));
      d = rdata;
      r = rresp;
      for (int k = 0; k < hold; k++) begin
         tick();
         check_val("hold_rvalid", 64'(rvalid), 64'(1));
         check_val("hold_rdata", 64'(rdata), 64'(d));
         check_val("hold_arready", 64'(arready), 64'(0));
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      check_val("rvalid_drop", 64'(rvalid), 64'(0));
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      logic [6:0]  a;
      logic [31:0] v;
      int          w;

      rst = 1'b1;
      awaddr = '0; awvalid = 0; wdata = '0; wvalid = 0; bready = 0;
      araddr = '0; arvalid = 0; rready = 0; cmd_ready = 0; tx_busy = 0;
      model_reset();
      #2;
      check_val("rst_awready", 64'(awready), 64'(0));
      check_val("rst_arready", 64'(arready), 64'(0));
      check_val("rst_cfg0", 64'(cfg[31:0]), 64'(TB_CTRL_RST));
      check_val("rst_cfg1", 64'(cfg[63:32]), 64'(0));
      check_val("rst_cmd_valid", 64'(cmd_valid), 64'(0));
      tick(); tick();
      rst = 1'b0;
      check_val("rel_wready_low", 64'(wready), 64'(0));
      tick();
      check_val("rel_wready_high", 64'(wready), 64'(1));

      // AW leads W by two cycles
      axi_write(7'h04, 32'hA5A5_0001, 0, 2, r, lat);
      m_cfg[1] = 32'hA5A5_0001;
      check_val("w04_lat", 64'(lat), 64'(1));
      check_val("w04_bresp", 64'(r), 64'(0));
      check_val("w04_cfg", 64'(cfg[63:32]), 64'(32'hA5A5_0001));
      axi_read(7'h04, 0, d, r);
      check_val("r04_data", 64'(d), 64'(model_rd(7'h04)));

      // Command held without consumer
      axi_write(7'h20, 32'h0000_0539, 0, 0, r, lat);
      m_cmd = 32'h0000_0539; m_cmd_valid = 1;
      check_val("cmd_valid", 64'(cmd_valid), 64'(1));
      check_val("cmd_data", 64'(cmd_data), 64'(32'h0000_0539));
      axi_read(7'h24, 0, d, r);
      check_val("status_pend", 64'(d), 64'(32'h0000_0400));
      repeat (3) tick();
      check_val("cmd_valid_held", 64'(cmd_valid), 64'(1));
      cmd_ready = 1; tick(); cmd_ready = 0;
      m_cmd_valid = 0;
      axi_read(7'h24, 0, d, r);
      check_val("status_clr", 64'(d), 64'(32'h0));

      // Second command stalls until the first is consumed
      axi_write(7'h20, 32'h0000_0111, 0, 0, r, lat);
      fork
         axi_write(7'h20, 32'h0000_0222, 1, 0, r, lat);
         begin
            repeat (6) tick();
            check_val("stall_bvalid", 64'(bvalid), 64'(0));
            check_val("stall_cmd_data", 64'(cmd_data), 64'(32'h0000_0111));
            cmd_ready = 1; tick(); cmd_ready = 0;
         end
      join
      m_cmd = 32'h0000_0222; m_cmd_valid = 1;
      check_val("stall_lat", 64'(lat > 5), 64'(1));
      check_val("stall_cmd2", 64'(cmd_data), 64'(32'h0000_0222));
      check_val("stall_valid2", 64'(cmd_valid), 64'(1));
      cmd_ready = 1; tick(); cmd_ready = 0;
      m_cmd_valid = 0;

      // Unmapped read, with rready withheld for 5 cycles
      axi_read(7'h7C, 5, d, r);
      check_val("r7c_data", 64'(d), 64'(0));
      check_val("r7c_resp", 64'(r), 64'(model_resp(0)));

      // Random traffic; consumer always ready
      cmd_ready = 1;
      for (int it = 0; it < 60; it++) begin
         tx_busy = 1'($urandom);
         case ($urandom_range(0, 4))
            0, 1: w = $urandom_range(0, TB_NUM_CFG - 1);
            2:    w = 8;
            3:    w = 9;
            default: w = $urandom_range(10, 31);
         endcase
         a = 7'(w * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) begin
            v = $urandom;
            axi_write(a, v, $urandom_range(0, 3), $urandom_range(0, 3), r, lat);
            check_val("rnd_w_lat", 64'(lat), 64'(1));
            check_val("rnd_w_resp", 64'(r), 64'(model_resp(model_mapped_wr(a))));
            if (w < TB_NUM_CFG) m_cfg[w] = v;
            if (w == 8) m_cmd = v;
            if (w < TB_NUM_CFG) check_val("rnd_cfg", 64'(cfg[32*w +: 32]), 64'(v));
         end else begin
            axi_read(a, $urandom_range(0, 2), d, r);
            check_val("rnd_r_data", 64'(d), 64'(model_rd(a)));
            check_val("rnd_r_resp", 64'(r), 64'(model_resp(model_mapped_rd(a))));
         end
      end
      cmd_ready = 0;
      tx_busy   = 0;

      // Reset during W_RESP with a pending command
      axi_write(7'h00, 32'hDEAD_BEEF, 0, 0, r, lat);
      axi_write(7'h20, 32'h0000_0777, 0, 0, r, lat);
      awaddr = 7'h08; wdata = 32'h5555_AAAA; awvalid = 1; wvalid = 1; bready = 0;
      tick();
      awvalid = 0; wvalid = 0;
      lat = 0;
      while (!bvalid && lat < 10) begin tick(); lat++; end
      check_val("pre_rst_bvalid", 64'(bvalid), 64'(1));
      check_val("pre_rst_cmd_valid", 64'(cmd_valid), 64'(1));
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_val("mid_rst_bvalid", 64'(bvalid), 64'(0));
      check_val("mid_rst_awready", 64'(awready), 64'(0));
      check_val("mid_rst_cmd_valid", 64'(cmd_valid), 64'(0));
      check_val("mid_rst_cmd_data", 64'(cmd_data), 64'(0));
      check_val("mid_rst_cfg0", 64'(cfg[31:0]), 64'(TB_CTRL_RST));
      check_val("mid_rst_cfg2", 64'(cfg[95:64]), 64'(0));
      check_val("mid_rst_bresp", 64'(bresp), 64'(0));
      tick(); tick();
      rst = 1'b0;
      check_val("rel2_arready_low", 64'(arready), 64'(0));
      tick();
      check_val("rel2_awready_high", 64'(awready), 64'(1));
      axi_read(7'h00, 0, d, r);
      check_val("post_rst_r00", 64'(d), 64'(model_rd(7'h00)));
      axi_read(7'h20, 0, d, r);
      check_val("post_rst_r20", 64'(d), 64'(model_rd(7'h20)));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
